// File: rtl/country_vehicle_detector.sv
// ----------------------------------------------------------------------------
// country_vehicle_detector
//
// Front-end for the country-road inductive loop of the junction controller.
// The raw loop signal is synchronised and then debounced by a small FSM.
// Every accepted vehicle arrival increments a waiting-queue counter. While the
// controller shows the country road green, vehicles are drained from the
// queue at a fixed rate. The request output x is asserted while any vehicle
// is still waiting.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive equal synchronised samples needed to accept
//                     a loop level change (>= 2)
//   DRAIN_CYCLES    - consecutive green cycles per departing vehicle (>= 1)
//   QUEUE_W         - width of the waiting-vehicle counter
//
// Ports:
//   clk           - system clock, rising edge
//   rst           - synchronous active-high reset
//   loop_raw      - asynchronous raw loop detector output (1 = metal present)
//   country_green - country-road green indication from the controller
//   x             - vehicle request to the controller (1 = vehicles waiting)
//   queue_count   - number of waiting vehicles
//   overflow      - sticky flag: an arrival was seen while the queue was full
//   det_state     - detector FSM state (debug)
// ----------------------------------------------------------------------------
module country_vehicle_detector #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DRAIN_CYCLES    = 3,
   parameter int QUEUE_W         = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               loop_raw,
   input  logic               country_green,
   output logic               x,
   output logic [QUEUE_W-1:0] queue_count,
   output logic               overflow,
   output logic [1:0]         det_state
);

   // Detector states; the encoding is visible on det_state.
   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      ARMING    = 2'b01,
      OCCUPIED  = 2'b10,
      RELEASING = 2'b11
   } det_state_e;

   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

   // Last count value before a qualified transition / departure.
   localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DRN_W-1:0]   DRN_LAST  = DRN_W'(DRAIN_CYCLES - 1);
   localparam logic [DEB_W-1:0]   DEB_ONE   = DEB_W'(1);
   localparam logic [DRN_W-1:0]   DRN_ONE   = DRN_W'(1);
   localparam logic [QUEUE_W-1:0] QUEUE_ONE = QUEUE_W'(1);
   localparam logic [QUEUE_W-1:0] QUEUE_MAX = '1;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic               s1_q, s1_d;
   logic               s2_q, s2_d;
   det_state_e         state_q, state_d;
   logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
   logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
   logic [QUEUE_W-1:0] queue_q, queue_d;
   logic               overflow_q, overflow_d;

   // One-cycle strobes, valid in the cycle before the edge they act on.
   logic               arrival;
   logic               departure;

   // -------------------------------------------------------------------------
   // Two-flop synchroniser; only s2 is used downstream.
   // -------------------------------------------------------------------------
   always_comb begin
      s1_d = loop_raw;
      s2_d = s1_q;
   end

   // -------------------------------------------------------------------------
   // Detector FSM. deb_cnt holds the number of consecutive samples already
   // seen at the new level, so entering ARMING/RELEASING loads 1 and the
   // transition fires when the stored count is DEBOUNCE_CYCLES-1 and the
   // current sample still agrees.
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_d   = state_q;
      deb_cnt_d = deb_cnt_q;
      arrival   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (s2_q) begin
               state_d   = ARMING;
               deb_cnt_d = DEB_ONE;
            end
         end

         ARMING: begin
            if (!s2_q) begin
               // Glitch: loop went away before it was qualified.
               state_d   = IDLE;
               deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d   = OCCUPIED;
               deb_cnt_d = '0;
               arrival   = 1'b1;
            end else begin
               deb_cnt_d = deb_cnt_q + DEB_ONE;
            end
         end

         OCCUPIED: begin
            if (!s2_q) begin
               state_d   = RELEASING;
               deb_cnt_d = DEB_ONE;
            end
         end

         RELEASING: begin
            if (s2_q) begin
               // Vehicle still there after a short dip: no new arrival.
               state_d   = OCCUPIED;
               deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d   = IDLE;
               deb_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + DEB_ONE;
            end
         end

         default: begin
            state_d   = IDLE;
            deb_cnt_d = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Drain counter: runs only while green and the queue is non-empty, so a
   // departure can never be raised against an empty queue.
   // -------------------------------------------------------------------------
   always_comb begin
      drain_cnt_d = '0;
      departure   = 1'b0;

      if (country_green && (queue_q != '0)) begin
         if (drain_cnt_q == DRN_LAST) begin
            departure   = 1'b1;
            drain_cnt_d = '0;
         end else begin
            drain_cnt_d = drain_cnt_q + DRN_ONE;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Queue counter. A simultaneous arrival and departure cancel, even when
   // the queue is full, so overflow is only flagged for a net arrival.
   // -------------------------------------------------------------------------
   always_comb begin
      queue_d    = queue_q;
      overflow_d = overflow_q;

      if (arrival && !departure) begin
         if (queue_q == QUEUE_MAX) begin
            overflow_d = 1'b1;
         end else begin
            queue_d = queue_q + QUEUE_ONE;
         end
      end else if (departure && !arrival) begin
         queue_d = queue_q - QUEUE_ONE;
      end
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before the edge, independent of statement order.
      if (rst) begin
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         state_q     <= IDLE;
         deb_cnt_q   <= '0;
         drain_cnt_q <= '0;
         queue_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         state_q     <= state_d;
         deb_cnt_q   <= deb_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         queue_q     <= queue_d;
         overflow_q  <= overflow_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs, all decoded from registered state only.
   // -------------------------------------------------------------------------
   assign x           = (queue_q != '0);
   assign queue_count = queue_q;
   assign overflow    = overflow_q;
   assign det_state   = state_q;

endmodule

// File: tb/tb_country_vehicle_detector.sv
// ----------------------------------------------------------------------------
// tb_country_vehicle_detector
//
// Directed and random stimulus for country_vehicle_detector. A reference model
// describes the detector as a debounced level plus a run length of samples
// disagreeing with it, and the queue as a plain integer; every step compares
// all outputs against it, and directed points add literal expectations.
// ----------------------------------------------------------------------------
module tb_country_vehicle_detector;

   localparam int DEB   = 4;
   localparam int DRAIN = 3;
   localparam int QW    = 4;
   localparam int QMAX  = (1 << QW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          loop_raw = 1'b0;
   logic          country_green = 1'b0;
   logic          x;
   logic [QW-1:0] queue_count;
   logic          overflow;
   logic [1:0]    det_state;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state
   logic m_s1, m_s2;      // synchroniser stages
   logic m_level;         // accepted (debounced) loop level
   int   m_run;           // consecutive samples disagreeing with m_level
   int   m_drain;         // consecutive qualifying green cycles
   int   m_q;             // waiting vehicles
   logic m_ovf;

   int   len;
   logic lv, gv;
   int   q_before;

   country_vehicle_detector #(
      .DEBOUNCE_CYCLES(DEB),
      .DRAIN_CYCLES   (DRAIN),
      .QUEUE_W        (QW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .loop_raw     (loop_raw),
      .country_green(country_green),
      .x            (x),
      .queue_count  (queue_count),
      .overflow     (overflow),
      .det_state    (det_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using its pre-edge state.
   task automatic model_edge(input logic l, input logic g, input logic r);
      logic arr, dep;
      if (r) begin
         m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0;
         m_drain = 0; m_q = 0; m_ovf = 0;
      end else begin
         arr = 0;
         if (m_s2 != m_level) begin
            m_run++;
            if (m_run == DEB) begin
               m_level = ~m_level;
               m_run   = 0;
               arr     = m_level;
            end
         end else begin
            m_run = 0;
         end

         dep = 0;
         if (g && m_q > 0) begin
            m_drain++;
            if (m_drain == DRAIN) begin
               dep     = 1;
               m_drain = 0;
            end
         end else begin
            m_drain = 0;
         end

         if (arr && !dep) begin
            if (m_q == QMAX) m_ovf = 1;
            else m_q++;
         end else if (dep && !arr) begin
            m_q--;
         end

         m_s2 = m_s1;
         m_s1 = l;
      end
   endtask

   task automatic compare_all();
      check("queue_count", 32'(queue_count), 32'(m_q));
      check("x", 32'(x), 32'(m_q != 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("det_state", 32'(det_state), 32'({m_level, m_run != 0}));
   endtask

   // Drive inputs, take one edge, sample 1 time unit later.
   task automatic step(input logic l, input logic g, input logic r);
      loop_raw      = l;
      country_green = g;
      rst           = r;
      @(posedge clk);
      model_edge(l, g, r);
      #1;
      compare_all();
   endtask

   task automatic add_vehicle();
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0;
      m_drain = 0; m_q = 0; m_ovf = 0;
      #1;

      // Reset state
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check("rst_queue", 32'(queue_count), 32'd0);
      check("rst_x", 32'(x), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_state", 32'(det_state), 32'd0);

      // 1. Basic arrival with latency DEB+1
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (i == 1) check("basic_idle_e1", 32'(det_state), 32'd0);
         if (i == 2) check("basic_arming_e2", 32'(det_state), 32'd1);
         if (i == 4) check("basic_q_e4", 32'(queue_count), 32'd0);
         if (i == 5) begin
            check("basic_q_e5", 32'(queue_count), 32'd1);
            check("basic_x_e5", 32'(x), 32'd1);
            check("basic_occ_e5", 32'(det_state), 32'd2);
         end
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (i == 2) check("basic_releasing", 32'(det_state), 32'd3);
         if (i == 5) check("basic_back_idle", 32'(det_state), 32'd0);
      end
      check("basic_q_kept", 32'(queue_count), 32'd1);

      // 2. Glitch rejection, then a one-sample dip while occupied
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
      check("glitch_q", 32'(queue_count), 32'd1);
      check("glitch_state", 32'(det_state), 32'd0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
      check("dip_single_count", 32'(queue_count), 32'd2);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);

      // 3. Drain of three vehicles, then drain restart after a green drop
      add_vehicle();
      check("drain_start_q", 32'(queue_count), 32'd3);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (i == 1) check("drain_g2", 32'(queue_count), 32'd3);
         if (i == 2) check("drain_g3", 32'(queue_count), 32'd2);
         if (i == 5) check("drain_g6", 32'(queue_count), 32'd1);
         if (i == 7) check("drain_x_g8", 32'(x), 32'd1);
         if (i == 8) begin
            check("drain_g9", 32'(queue_count), 32'd0);
            check("drain_x_g9", 32'(x), 32'd0);
         end
      end
      add_vehicle();
      add_vehicle();
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check("restart_no_depart", 32'(queue_count), 32'd2);
      step(1'b0, 1'b1, 1'b0);
      check("restart_depart", 32'(queue_count), 32'd1);

      // 4. Saturation and sticky overflow
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) add_vehicle();
      check("sat_q15_no_ovf", 32'(overflow), 32'd0);
      add_vehicle();
      check("sat_q", 32'(queue_count), 32'd15);
      check("sat_ovf", 32'(overflow), 32'd1);
      for (int i = 0; i < 48; i++) step(1'b0, 1'b1, 1'b0);
      check("sat_drained", 32'(queue_count), 32'd0);
      check("sat_ovf_sticky", 32'(overflow), 32'd1);
      step(1'b0, 1'b0, 1'b1);
      check("sat_ovf_rst", 32'(overflow), 32'd0);

      // 5. Arrival and departure on the same edge
      add_vehicle();
      add_vehicle();
      for (int i = 0; i < 6; i++) step(1'b1, (i >= 3), 1'b0);
      check("simul_q", 32'(queue_count), 32'd2);
      check("simul_x", 32'(x), 32'd1);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);

      // 6. Reset during ARMING with drain progress, then full requalification
      for (int i = 0; i < 3; i++) step(1'b1, (i >= 1), 1'b0);
      check("mid_arming", 32'(det_state), 32'd1);
      check("mid_q", 32'(queue_count), 32'd2);
      step(1'b1, 1'b0, 1'b1);
      check("mid_rst_q", 32'(queue_count), 32'd0);
      check("mid_rst_state", 32'(det_state), 32'd0);
      check("mid_rst_x", 32'(x), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (i == 4) check("mid_requal_wait", 32'(queue_count), 32'd0);
         if (i == 5) check("mid_requal_count", 32'(queue_count), 32'd1);
      end
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);

      // Random runs of loop level and green, rare resets
      for (int k = 0; k < 150; k++) begin
         len = $urandom_range(1, 9);
         lv  = 1'($urandom_range(0, 1));
         gv  = ($urandom_range(0, 2) == 0);
         for (int j = 0; j < len; j++)
            step(lv, gv, ($urandom_range(0, 299) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
